output_display_module: RTL and testbench

//   Downstream consumer of the output register. Captures the 8-bit OUT value on a load strobe.

---
 rtl/output_display_module.sv | 182 ++++++++++++++++++
 tb/tb_output_display_module.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/output_display_module.sv
// output_display_module
//   Captures an 8-bit value on a load strobe and converts it to BCD with a
//   sequential double-dabble, one shift per clock. The result drives a 4-digit
//   multiplexed common-anode 7-segment display. The display digit registers
//   change only on a commit, so a value is never shown half-converted.
//   Config macro: SIGNED_DISPLAY_EN. When defined, data is two's complement
//   and digit 3 shows a minus sign for negative values.
// Ports
//   clk  : system clock
//   rst  : synchronous active-low reset
//   load : 1-cycle strobe; data holds a new value
//   data : value to display
//   busy : a conversion is in progress or a value is pending
//   seg  : segments {g,f,e,d,c,b,a}, active-low
//   an   : digit enables, active-low one-hot; an[0] is the units digit
module output_display_module #(
    parameter int unsigned SCAN_DIV      = 50000,
    parameter int unsigned LEADING_BLANK = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] an
);
    localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;
    localparam logic [6:0]  SEG_MINUS = 7'b0111111;
    localparam logic [6:0]  SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_COMMIT} state_t;

    state_t           r_state;
    logic [19:0]      r_shift;       // {hundreds, tens, units, binary}
    logic [2:0]       r_bits;
    logic [7:0]       r_pend;
    logic             r_pend_valid;
    logic [3:0][6:0]  r_dig;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
`ifdef SIGNED_DISPLAY_EN
    logic             r_neg;
`endif

    logic [19:0]      w_adj;
    logic [3:0][6:0]  w_dig;
    logic [1:0]       w_idx_nxt;
    logic [7:0]       w_start_val;

    // Standard digit patterns; anything else renders blank.
    function automatic logic [6:0] f_seg7(input logic [3:0] d);
        case (d)
            4'd0:    f_seg7 = 7'b1000000;
            4'd1:    f_seg7 = 7'b1111001;
            4'd2:    f_seg7 = 7'b0100100;
            4'd3:    f_seg7 = 7'b0110000;
            4'd4:    f_seg7 = 7'b0011001;
            4'd5:    f_seg7 = 7'b0010010;
            4'd6:    f_seg7 = 7'b0000010;
            4'd7:    f_seg7 = 7'b1111000;
            4'd8:    f_seg7 = 7'b0000000;
            4'd9:    f_seg7 = 7'b0010000;
            default: f_seg7 = SEG_BLANK;
        endcase
    endfunction

    // Magnitude of the captured value; -128 maps to 128 as unsigned.
    function automatic logic [7:0] f_mag(input logic [7:0] v);
`ifdef SIGNED_DISPLAY_EN
        f_mag = v[7] ? 8'(~v + 8'd1) : v;
`else
        f_mag = v;
`endif
    endfunction

    // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift.
    always_comb begin
        w_adj = r_shift;
        for (int h = 0; h < 3; h++) begin
            if (r_shift[8 + 4*h +: 4] >= 4'd5)
                w_adj[8 + 4*h +: 4] = r_shift[8 + 4*h +: 4] + 4'd3;
        end
    end

    // Display patterns for the finished BCD result, including leading blanks.
    always_comb begin
        w_dig[0] = f_seg7(r_shift[11:8]);
        w_dig[1] = f_seg7(r_shift[15:12]);
        w_dig[2] = f_seg7(r_shift[19:16]);
        w_dig[3] = SEG_BLANK;
        if (LEADING_BLANK != 0) begin
            if (r_shift[19:16] == 4'd0) begin
                w_dig[2] = SEG_BLANK;
                if (r_shift[15:12] == 4'd0)
                    w_dig[1] = SEG_BLANK;
            end
        end
`ifdef SIGNED_DISPLAY_EN
        if (r_neg)
            w_dig[3] = SEG_MINUS;
`endif
    end

    // A load on the commit edge is newer than anything pending, so it wins.
    assign w_start_val = load ? data : r_pend;
    assign w_idx_nxt   = r_idx + 2'd1;

    // Control FSM: capture, shift, commit, and chain into the pending value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_bits       <= '0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            busy         <= 1'b0;
            r_dig        <= {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_ZERO};
`ifdef SIGNED_DISPLAY_EN
            r_neg        <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_shift <= {12'd0, f_mag(data)};
                        r_bits  <= '0;
                        busy    <= 1'b1;
                        r_state <= S_CONVERT;
`ifdef SIGNED_DISPLAY_EN
                        r_neg   <= data[7];
`endif
                    end
                end
                S_CONVERT: begin
                    r_shift <= w_adj << 1;
                    r_bits  <= r_bits + 3'd1;
                    if (r_bits == 3'd7)
                        r_state <= S_COMMIT;
                    if (load) begin
                        r_pend       <= data;
                        r_pend_valid <= 1'b1;
                    end
                end
                S_COMMIT: begin
                    r_dig <= w_dig;
                    if (load || r_pend_valid) begin
                        r_shift      <= {12'd0, f_mag(w_start_val)};
                        r_bits       <= '0;
                        r_pend_valid <= 1'b0;
                        r_state      <= S_CONVERT;
`ifdef SIGNED_DISPLAY_EN
                        r_neg        <= w_start_val[7];
`endif
                    end else begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Free-running scan; an and seg move together at each wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
            r_idx <= '0;
            an    <= 4'b1110;
            seg   <= SEG_ZERO;
        end else if (r_cnt == CNT_W'(SCAN_DIV - 1)) begin
            r_cnt <= '0;
            r_idx <= w_idx_nxt;
            an    <= ~(4'b0001 << w_idx_nxt);
            seg   <= r_dig[w_idx_nxt];
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_output_display_module.sv
module tb_output_display_module;
    localparam int unsigned SD = 4;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] MI = 7'b0111111;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [7:0] data = 8'd0;
    logic       busy, busy0;
    logic [6:0] seg, seg0;
    logic [3:0] an, an0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    output_display_module #(.SCAN_DIV(SD), .LEADING_BLANK(1)) u_dut (
        .clk(clk), .rst(rst), .load(load), .data(data),
        .busy(busy), .seg(seg), .an(an));
    output_display_module #(.SCAN_DIV(SD), .LEADING_BLANK(0)) u_dut0 (
        .clk(clk), .rst(rst), .load(load), .data(data),
        .busy(busy0), .seg(seg0), .an(an0));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         cyc = 0;
    bit         m_valid = 0;
    bit         m_busy, m_pv;
    int         m_commit_at, m_job, m_pend;
    logic [6:0] m_d1[4];
    logic [6:0] m_d0[4];
    logic [3:0] m_an;
    logic [6:0] m_seg1, m_seg0;
    int         m_cnt, m_idx;

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] t[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return t[d];
    endfunction

    task automatic m_commit(input int raw);
        int v, h, t, u;
        bit neg;
`ifdef SIGNED_DISPLAY_EN
        neg = raw >= 128;
        v = neg ? 256 - raw : raw;
`else
        neg = 0;
        v = raw;
`endif
        h = v / 100; t = (v / 10) % 10; u = v % 10;
        m_d1[0] = seg_of(u);
        m_d1[1] = (h == 0 && t == 0) ? BL : seg_of(t);
        m_d1[2] = (h == 0) ? BL : seg_of(h);
        m_d1[3] = neg ? MI : BL;
        m_d0[0] = seg_of(u);
        m_d0[1] = seg_of(t);
        m_d0[2] = seg_of(h);
        m_d0[3] = neg ? MI : BL;
    endtask

    task automatic m_start(input int v);
        m_job = v;
        m_commit_at = cyc + 9;
        m_busy = 1;
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            m_valid = 1; m_busy = 0; m_pv = 0; m_cnt = 0; m_idx = 0;
            for (int i = 0; i < 4; i++) begin
                m_d1[i] = (i == 0) ? 7'h40 : BL;
                m_d0[i] = (i == 0) ? 7'h40 : BL;
            end
            m_an = 4'b1110; m_seg1 = 7'h40; m_seg0 = 7'h40;
        end else begin
            // Scan latches the digits as they stood before this edge.
            if (m_cnt == SD - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 4;
                m_an = ~(4'(1) << m_idx);
                m_seg1 = m_d1[m_idx];
                m_seg0 = m_d0[m_idx];
            end else begin
                m_cnt++;
            end
            if (!m_busy) begin
                if (load) m_start(int'(data));
            end else if (cyc == m_commit_at) begin
                m_commit(m_job);
                if (load) begin m_start(int'(data)); m_pv = 0; end
                else if (m_pv) begin m_start(m_pend); m_pv = 0; end
                else m_busy = 0;
            end else if (load) begin
                m_pend = int'(data);
                m_pv = 1;
            end
        end
        cyc++;
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("busy_lb0", 32'(busy0), 32'(m_busy));
            chk("an", 32'(an), 32'(m_an));
            chk("an_lb0", 32'(an0), 32'(m_an));
            chk("seg", 32'(seg), 32'(m_seg1));
            chk("seg_lb0", 32'(seg0), 32'(m_seg0));
        end
    end

    // ---------------- directed helpers ----------------
    logic [6:0] rd[4];
    logic [6:0] rd0[4];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        data = v; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Wait for idle, let every digit refresh, then read one full scan.
    task automatic read_disp;
        int k = 0;
        while (busy && k < 100) begin tick(); k++; end
        chk("idle_wait", 32'(busy), 32'd0);
        repeat (4 * SD + 1) tick();
        for (int i = 0; i < 4 * SD; i++) begin
            tick();
            for (int j = 0; j < 4; j++) begin
                if (an == ~(4'(1) << j)) rd[j] = seg;
                if (an0 == ~(4'(1) << j)) rd0[j] = seg0;
            end
        end
    endtask

    task automatic chk_disp(input string name, input logic [27:0] e1, input logic [27:0] e0);
        chk(name, 32'({rd[3], rd[2], rd[1], rd[0]}), 32'(e1));
        chk({name, "_lb0"}, 32'({rd0[3], rd0[2], rd0[1], rd0[0]}), 32'(e0));
    endtask

    task automatic lit(input logic [7:0] v, input string name,
                       input logic [27:0] e1, input logic [27:0] e0);
        do_load(v);
        read_disp();
        chk_disp(name, e1, e0);
    endtask

    initial begin
        logic [3:0] an_seq[4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        int c;

        // Reset state and scan order
        rst = 1'b0;
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_an", 32'(an), 32'b1110);
        chk("rst_seg", 32'(seg), 32'b1000000);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            repeat (SD) tick();
            chk("scan_an", 32'(an), 32'(an_seq[k]));
        end
        read_disp();
        chk_disp("rst_digits", {BL, BL, BL, 7'h40}, {BL, BL, BL, 7'h40});

        // Latency: busy visible for exactly 9 samples after the load edge
        do_load(8'd173);
        c = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy) c++;
            tick();
        end
        chk("busy_len", 32'(c), 32'd9);
        read_disp();
`ifdef SIGNED_DISPLAY_EN
        chk_disp("d173", {MI, BL, 7'h00, 7'h30}, {MI, 7'h40, 7'h00, 7'h30});
`else
        chk_disp("d173", {BL, 7'h79, 7'h78, 7'h30}, {BL, 7'h79, 7'h78, 7'h30});
`endif

        // Overlap and overwrite: 42, then 99 and 7 while busy; 7 wins
        do_load(8'd42);
        tick(); tick();
        do_load(8'd99);
        tick();
        do_load(8'd7);
        c = 0;
        for (int i = 0; i < 16; i++) begin
            if (busy) c++;
            tick();
        end
        chk("overlap_busy", 32'(c), 32'd13);
        read_disp();
        chk_disp("d7", {BL, BL, BL, 7'h78}, {BL, 7'h40, 7'h40, 7'h78});

        // Boundaries and leading blanks
        lit(8'd0,   "d0",   {BL, BL, BL, 7'h40},      {BL, 7'h40, 7'h40, 7'h40});
        lit(8'd5,   "d5",   {BL, BL, BL, 7'h12},      {BL, 7'h40, 7'h40, 7'h12});
        lit(8'd100, "d100", {BL, 7'h79, 7'h40, 7'h40}, {BL, 7'h79, 7'h40, 7'h40});
`ifdef SIGNED_DISPLAY_EN
        lit(8'h80, "d80", {MI, 7'h79, 7'h24, 7'h00}, {MI, 7'h79, 7'h24, 7'h00});
        lit(8'hFF, "dFF", {MI, BL, BL, 7'h79},       {MI, 7'h40, 7'h40, 7'h79});
        lit(8'h7F, "d7F", {BL, 7'h79, 7'h24, 7'h78}, {BL, 7'h79, 7'h24, 7'h78});
`else
        lit(8'd255, "d255", {BL, 7'h24, 7'h12, 7'h12}, {BL, 7'h24, 7'h12, 7'h12});
`endif

        // Reset mid-conversion: 200 must never commit
        do_load(8'd200);
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midrst_busy", 32'(busy), 32'd0);
        read_disp();
        chk_disp("midrst_digits", {BL, BL, BL, 7'h40}, {BL, BL, BL, 7'h40});

        // Randomized traffic checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            data = 8'($urandom);
            load = ($urandom_range(0, 3) == 0);
            rst  = ($urandom_range(0, 499) != 0);
            tick();
        end
        load = 1'b0;
        rst = 1'b1;
        repeat (40) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
